fifo_cascade: RTL and testbench

Single-clock FIFO built from two identical synchronous FIFO stages in series. An internal transfer path drains stage 0 into stage 1 automatically. Total capacity is 2×DEPTH words. It sits between a bursty producer and a slower consumer, buffering a full 1024-word burst of 36-bit words at default settings.

---
 rtl/fifo_cascade_pkg.sv | 19 +
 rtl/fifo_stage.sv | 68 ++++++
 rtl/fifo_cascade.sv | 78 +++++++
 tb/tb_fifo_cascade.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_cascade_pkg.sv
// Shared constants and width helpers for the two-stage cascaded FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_cascade_pkg;

   localparam int DEF_WIDTH = 36;
   localparam int DEF_DEPTH = 512;

   // Pointer width: indexes DEPTH entries (DEPTH is a power of two).
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // Counter width: one extra bit so the counter can hold DEPTH itself.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_stage.sv
// Synchronous circular-buffer FIFO stage with occupancy counter.
// Latency: push visible in count/empty after the pushing edge; head word (dout) is combinational from memory.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, rst_n (sync, active-low); push/din write side; pop/dout read side;
//        full, empty, count are all decoded from the registered counter.
module fifo_stage
   import fifo_cascade_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int PW   = ptr_width(DEPTH),
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    cnt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Storage is not reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr] <= din;
      end
   end

   // Pointers wrap DEPTH-1 -> 0 naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + PW'(1);
         end
         if (pop_ok) begin
            rptr <= rptr + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign dout  = mem[rptr];
   assign count = cnt;

endmodule

// File: rtl/fifo_cascade.sv
// Two fifo_stage instances in series with an automatic one-word-per-cycle transfer between them.
// Latency: write to readable 2 cycles when empty; read data registered, valid the cycle after rd_en.
// Backpressure: full (stage 0 full) drops writes; empty (stage 1 empty) ignores reads, dout holds.
// Ports: clk, rst_n (sync, active-low); wr_en/din write side; rd_en/dout read side; full, empty flags.
module fifo_cascade
   import fifo_cascade_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int CW = cnt_width(DEPTH);

   logic             s0_full;
   logic             s0_empty;
   logic             s1_full;
   logic             s1_empty;
   logic             xfer;
   logic [WIDTH-1:0] s0_dout;
   logic [WIDTH-1:0] s1_dout;
   logic [CW-1:0]    s0_count;
   logic [CW-1:0]    s1_count;

   // Flags come straight from registered counters, so xfer has no path from the ports.
   assign xfer = ~s0_empty & ~s1_full;

   fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stage0 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .din   (din),
      .pop   (xfer),
      .dout  (s0_dout),
      .full  (s0_full),
      .empty (s0_empty),
      .count (s0_count)
   );

   fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stage1 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer),
      .din   (s0_dout),
      .pop   (rd_en),
      .dout  (s1_dout),
      .full  (s1_full),
      .empty (s1_empty),
      .count (s1_count)
   );

   assign full  = s0_full;
   assign empty = s1_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (rd_en & ~s1_empty) begin
         dout <= s1_dout;
      end
   end

   // Occupancy can never exceed one stage's depth.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (s0_count <= CW'(DEPTH) && s1_count <= CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_fifo_cascade.sv
module tb_fifo_cascade;

   localparam int WIDTH = 36;
   localparam int DEPTH = 512;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;

   int total = 0;
   int bad   = 0;

   // Reference model: per-stage occupancy plus an end-to-end scoreboard queue.
   int               m0 = 0;
   int               m1 = 0;
   logic [WIDTH-1:0] sb_q [$];
   logic [WIDTH-1:0] exp_dout  = '0;
   logic             exp_full  = 1'b0;
   logic             exp_empty = 1'b1;

   fifo_cascade #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en),
      .din   (din),
      .rd_en (rd_en),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, advance the model across the edge, settle 1 time unit.
   task automatic tick(input logic w, input logic [WIDTH-1:0] d, input logic r);
      logic wa;
      logic xf;
      logic ra;
      wr_en = w;
      din   = d;
      rd_en = r;
      @(posedge clk);
      if (!rst_n) begin
         m0 = 0;
         m1 = 0;
         sb_q.delete();
         exp_dout = '0;
      end else begin
         wa = w && (m0 != DEPTH);
         xf = (m0 != 0) && (m1 != DEPTH);
         ra = r && (m1 != 0);
         if (ra) exp_dout = sb_q.pop_front();
         if (wa) sb_q.push_back(d);
         m0 = m0 + int'(wa) - int'(xf);
         m1 = m1 + int'(xf) - int'(ra);
      end
      exp_full  = (m0 == DEPTH);
      exp_empty = (m1 == 0);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, WIDTH'($urandom), 1'b1);
         total++;
         if (full !== 1'b0 || empty !== 1'b1 || dout !== '0) begin
            bad++;
            $display("FAIL reset[%0d]: full=%b empty=%b dout=%h, want full=0 empty=1 dout=0", i, full, empty, dout);
         end
      end
      rst_n = 1'b1;
      tick(1'b0, '0, 1'b0);
      total++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         bad++;
         $display("FAIL reset_nothing_stored: full=%b empty=%b, want full=0 empty=1", full, empty);
      end
   endtask

   task automatic test_single();
      tick(1'b1, 36'h1, 1'b0);
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL single_empty_after_write: empty=%b, want 1", empty);
      end
      tick(1'b0, '0, 1'b0);
      total++;
      if (empty !== 1'b0) begin
         bad++;
         $display("FAIL single_empty_2cyc: empty=%b, want 0", empty);
      end
      tick(1'b0, '0, 1'b1);
      total++;
      if (dout !== 36'h1 || empty !== 1'b1 || dout !== exp_dout) begin
         bad++;
         $display("FAIL single_read: dout=%h empty=%b, want dout=1 empty=1", dout, empty);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 1032; i++) begin
         tick(1'b1, WIDTH'(i), 1'b0);
         total++;
         if (full !== exp_full || empty !== exp_empty || dout !== exp_dout) begin
            bad++;
            $display("FAIL fill[%0d]: full=%b empty=%b dout=%h, want %b %b %h", i, full, empty, dout, exp_full, exp_empty, exp_dout);
         end
         if (i == 1023 || i == 1024) begin
            total++;
            if (full !== (i == 1024)) begin
               bad++;
               $display("FAIL fill_full_edge[%0d]: full=%b, want %b", i, full, (i == 1024));
            end
         end
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 1030; i++) begin
         tick(1'b0, '0, 1'b1);
         total++;
         if (full !== exp_full || empty !== exp_empty || dout !== exp_dout) begin
            bad++;
            $display("FAIL drain[%0d]: full=%b empty=%b dout=%h, want %b %b %h", i, full, empty, dout, exp_full, exp_empty, exp_dout);
         end
         total++;
         if (dout !== WIDTH'((i <= 1024) ? i : 1024)) begin
            bad++;
            $display("FAIL drain_seq[%0d]: dout=%h, want %h", i, dout, WIDTH'((i <= 1024) ? i : 1024));
         end
         if (i <= 2) begin
            total++;
            if (full !== (i == 1)) begin
               bad++;
               $display("FAIL drain_full_fall[%0d]: full=%b, want %b", i, full, (i == 1));
            end
         end
         if (i == 1023 || i == 1024) begin
            total++;
            if (empty !== (i == 1024)) begin
               bad++;
               $display("FAIL drain_empty_rise[%0d]: empty=%b, want %b", i, empty, (i == 1024));
            end
         end
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 200; i++) begin
         tick(1'b1, WIDTH'(5000 + i), 1'b1);
         total++;
         if (full !== 1'b0 || empty !== exp_empty || dout !== exp_dout) begin
            bad++;
            $display("FAIL stream[%0d]: full=%b empty=%b dout=%h, want 0 %b %h", i, full, empty, dout, exp_empty, exp_dout);
         end
         if (i >= 2) begin
            total++;
            if (dout !== WIDTH'(5000 + i - 2)) begin
               bad++;
               $display("FAIL stream_nogap[%0d]: dout=%h, want %h", i, dout, WIDTH'(5000 + i - 2));
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, '0, 1'b1);
         total++;
         if (full !== exp_full || empty !== exp_empty || dout !== exp_dout) begin
            bad++;
            $display("FAIL stream_tail[%0d]: full=%b empty=%b dout=%h, want %b %b %h", i, full, empty, dout, exp_full, exp_empty, exp_dout);
         end
      end
      total++;
      if (dout !== WIDTH'(5199) || empty !== 1'b1) begin
         bad++;
         $display("FAIL stream_last: dout=%h empty=%b, want %h 1", dout, empty, WIDTH'(5199));
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 1; i <= 300; i++) begin
         tick(1'b1, WIDTH'(9000 + i), (i == 150));
      end
      total++;
      if (empty !== 1'b0 || dout !== WIDTH'(9001)) begin
         bad++;
         $display("FAIL midrst_pre: empty=%b dout=%h, want 0 %h", empty, dout, WIDTH'(9001));
      end
      rst_n = 1'b0;
      tick(1'b1, WIDTH'(36'hDEAD), 1'b1);
      rst_n = 1'b1;
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
         bad++;
         $display("FAIL midrst_flags: full=%b empty=%b dout=%h, want 0 1 0", full, empty, dout);
      end
      tick(1'b1, WIDTH'(36'hABC), 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b1);
      total++;
      if (dout !== WIDTH'(36'hABC) || empty !== 1'b1 || dout !== exp_dout) begin
         bad++;
         $display("FAIL midrst_new_data: dout=%h empty=%b, want abc 1", dout, empty);
      end
      tick(1'b0, '0, 1'b1);
      total++;
      if (dout !== WIDTH'(36'hABC) || empty !== 1'b1) begin
         bad++;
         $display("FAIL midrst_no_old: dout=%h empty=%b, want abc 1", dout, empty);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_stream();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
